cordic_sincos_iter: RTL and testbench

CORDIC_SINCOS_ITER -- requirements
Module: cordic_sincos_iter

---
 rtl/cordic_sincos_iter_if.sv | 11 +
 rtl/cordic_sincos_iter.sv | 137 +++++++++++++
 tb/tb_cordic_sincos_iter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cordic_sincos_iter_if.sv
// cordic_sincos_iter_if: request (start/angle) and result (ready/done/cos/sin) bundle
interface cordic_sincos_iter_if #(parameter int WIDTH = 22);
    logic                    start;
    logic signed [WIDTH-1:0] angle;
    logic                    ready;
    logic                    done;
    logic signed [WIDTH-1:0] cos_out;
    logic signed [WIDTH-1:0] sin_out;
    modport master (output start, angle, input ready, done, cos_out, sin_out);
    modport slave (input start, angle, output ready, done, cos_out, sin_out);
endinterface

// File: rtl/cordic_sincos_iter.sv
// cordic_sincos_iter: iterative rotation-mode CORDIC sine/cosine, UNROLL micro-iterations per clock
module cordic_sincos_iter #(
    parameter int WIDTH  = 22,
    parameter int ITERS  = 16,
    parameter int UNROLL = 4
) (
    input logic clock,
    input logic aclr_n,
    input logic clk_en,
    cordic_sincos_iter_if.slave bus
);
    localparam int  FRAC  = WIDTH - 3;
    localparam int  CW    = $clog2(ITERS + 1);
    localparam int  IW    = $clog2(ITERS);
    localparam real SCALE = real'(64'd1 << FRAC);
    localparam logic signed [WIDTH-1:0] PI_Q  = WIDTH'(longint'(3.14159265358979323846 * SCALE));
    localparam logic signed [WIDTH-1:0] HPI_Q = WIDTH'(longint'(1.57079632679489661923 * SCALE));
    localparam logic signed [WIDTH-1:0] K_Q   = WIDTH'(longint'(0.6072529350 * SCALE));

    if (ITERS % UNROLL != 0) begin : g_chk
        $error("ITERS must be a multiple of UNROLL");
    end

    // beyond the listed entries atan(2^-k) equals 2^-k to well below one LSB
    function automatic real atan_pow2(input int k);
        case (k)
            0:       return 0.7853981633974483;
            1:       return 0.4636476090008061;
            2:       return 0.24497866312686414;
            3:       return 0.12435499454676144;
            4:       return 0.06241880999595735;
            5:       return 0.031239833430268277;
            6:       return 0.015623728620476831;
            7:       return 0.007812341060101111;
            8:       return 0.0039062301319669718;
            9:       return 0.0019531225164788188;
            10:      return 0.0009765621895593195;
            11:      return 0.0004882812111948983;
            12:      return 0.00024414062014936177;
            13:      return 0.00012207031189367021;
            14:      return 0.00006103515617420877;
            15:      return 0.000030517578115526096;
            16:      return 0.000015258789061315762;
            17:      return 0.00000762939453110197;
            18:      return 0.000003814697265606496;
            19:      return 0.000001907348632810187;
            default: return 1.0 / real'(64'd1 << k);
        endcase
    endfunction

    logic signed [WIDTH-1:0] atan_tab [ITERS];
    for (genvar g = 0; g < ITERS; g++) begin : g_atan
        assign atan_tab[g] = WIDTH'(longint'(atan_pow2(g) * SCALE));
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           i, i_n, k;
    logic signed [WIDTH-1:0] x, y, z, x_n, y_n, z_n;
    logic signed [WIDTH-1:0] cos_q, sin_q, cos_n, sin_n;
    logic signed [WIDTH-1:0] ca, cx, cy, cz, tx, ty;
    logic                    neg, neg_n;

    always_comb begin
        ca = bus.angle > PI_Q ? PI_Q : bus.angle < -PI_Q ? -PI_Q : bus.angle;
        cx = x;
        cy = y;
        cz = z;
        k  = i;
        tx = '0;
        ty = '0;
        for (int u = 0; u < UNROLL; u++) begin
            k  = i + CW'(u);
            tx = cx >>> k;
            ty = cy >>> k;
            cx = cz[WIDTH-1] ? cx + ty : cx - ty;
            cy = cz[WIDTH-1] ? cy - tx : cy + tx;
            cz = cz[WIDTH-1] ? cz + atan_tab[IW'(k)] : cz - atan_tab[IW'(k)];
        end
        state_n = state;
        i_n     = i;
        x_n     = x;
        y_n     = y;
        z_n     = z;
        neg_n   = neg;
        cos_n   = cos_q;
        sin_n   = sin_q;
        if (state == IDLE && bus.start) begin
            state_n = RUN;
            i_n     = '0;
            x_n     = K_Q;
            y_n     = '0;
            neg_n   = ca > HPI_Q || ca < -HPI_Q;
            z_n     = ca > HPI_Q ? ca - PI_Q : ca < -HPI_Q ? ca + PI_Q : ca;
        end else if (state == RUN) begin
            i_n = i + CW'(UNROLL);
            x_n = cx;
            y_n = cy;
            z_n = cz;
            if (i == CW'(ITERS - UNROLL)) begin
                state_n = DONE;
                cos_n   = neg ? -cx : cx;
                sin_n   = neg ? -cy : cy;
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= IDLE;
            i     <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            neg   <= 1'b0;
            cos_q <= '0;
            sin_q <= '0;
        end else if (clk_en) begin
            state <= state_n;
            i     <= i_n;
            x     <= x_n;
            y     <= y_n;
            z     <= z_n;
            neg   <= neg_n;
            cos_q <= cos_n;
            sin_q <= sin_n;
        end
    end

    assign bus.ready   = state == IDLE;
    assign bus.done    = state == DONE;
    assign bus.cos_out = cos_q;
    assign bus.sin_out = sin_q;
endmodule

// File: tb/tb_cordic_sincos_iter.sv
// tb_cordic_sincos_iter: UNROLL=4/1/16 builds side by side, checked against real-valued cos/sin
module tb_cordic_sincos_iter;
    localparam int PI_Q  = 1647099;
    localparam int HPI_Q = 823550;
    localparam int TOL   = 32;

    logic clock = 1'b0;
    logic aclr_n = 1'b0;
    logic clk_en = 1'b1;
    logic start = 1'b0;
    logic signed [21:0] ang = '0;
    int n_cmp = 0;
    int n_bad = 0;
    int unr [3] = '{4, 1, 16};

    logic [2:0] dn, rdy;
    logic signed [21:0] co [3];
    logic signed [21:0] si [3];
    logic signed [21:0] res_c [3];
    logic signed [21:0] res_s [3];

    cordic_sincos_iter_if #(.WIDTH(22)) b4 ();
    cordic_sincos_iter_if #(.WIDTH(22)) b1 ();
    cordic_sincos_iter_if #(.WIDTH(22)) b16 ();

    cordic_sincos_iter #(.WIDTH(22), .ITERS(16), .UNROLL(4))  u4  (.clock(clock), .aclr_n(aclr_n), .clk_en(clk_en), .bus(b4));
    cordic_sincos_iter #(.WIDTH(22), .ITERS(16), .UNROLL(1))  u1  (.clock(clock), .aclr_n(aclr_n), .clk_en(clk_en), .bus(b1));
    cordic_sincos_iter #(.WIDTH(22), .ITERS(16), .UNROLL(16)) u16 (.clock(clock), .aclr_n(aclr_n), .clk_en(clk_en), .bus(b16));

    assign b4.start  = start;
    assign b1.start  = start;
    assign b16.start = start;
    assign b4.angle  = ang;
    assign b1.angle  = ang;
    assign b16.angle = ang;
    assign dn  = {b16.done, b1.done, b4.done};
    assign rdy = {b16.ready, b1.ready, b4.ready};
    assign co[0] = b4.cos_out;
    assign co[1] = b1.cos_out;
    assign co[2] = b16.cos_out;
    assign si[0] = b4.sin_out;
    assign si[1] = b1.sin_out;
    assign si[2] = b16.sin_out;

    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
        n_cmp++;
        if (got > exp + tol || got < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // one request to all three builds; stall freezes edges 2..4, pulse re-asserts start during RUN
    task automatic run_op(input int a, input bit stall, input bit pulse);
        int lat [3];
        int pul [3];
        int ac, l;
        real r;
        longint ec, es;
        lat = '{0, 0, 0};
        pul = '{0, 0, 0};
        @(negedge clock);
        ang = 22'(a);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int n = 1; n <= 26; n++) begin
            @(negedge clock);
            for (int d = 0; d < 3; d++)
                if (dn[d]) begin
                    pul[d]++;
                    if (lat[d] == 0) begin
                        lat[d] = n;
                        res_c[d] = co[d];
                        res_s[d] = si[d];
                    end
                end
            if (pulse && n == 1) start = 1'b1;
            if (pulse && n == 2) begin
                chk("ready in RUN u4", rdy[0], 0, 0);
                chk("ready in RUN u1", rdy[1], 0, 0);
                start = 1'b0;
            end
            if (stall && n == 1) clk_en = 1'b0;
            if (stall && n == 4) clk_en = 1'b1;
        end
        ac = a > PI_Q ? PI_Q : (a < -PI_Q ? -PI_Q : a);
        r  = real'(ac) / 524288.0;
        ec = longint'($cos(r) * 524288.0);
        es = longint'($sin(r) * 524288.0);
        for (int d = 0; d < 3; d++) begin
            l = 16 / unr[d];
            chk($sformatf("latency u%0d a=%0d", unr[d], a), lat[d], (stall && l > 1) ? l + 3 : l, 0);
            chk($sformatf("done cycles u%0d a=%0d", unr[d], a), pul[d], (stall && l == 1) ? 4 : 1, 0);
            chk($sformatf("cos u%0d a=%0d", unr[d], a), res_c[d], ec, TOL);
            chk($sformatf("sin u%0d a=%0d", unr[d], a), res_s[d], es, TOL);
        end
    endtask

    int dir_a  [5] = '{0, 823550, -411775, 1235325, 2097151};
    int dir_c  [5] = '{524288, 0, 370727, -370727, -524288};
    int dir_s  [5] = '{0, 524288, -370727, 370727, 0};
    int edge_a [10] = '{PI_Q, -PI_Q, HPI_Q + 1, HPI_Q - 1, -HPI_Q, -HPI_Q - 1, -HPI_Q + 1, -2097152, PI_Q + 1, 1};
    logic signed [21:0] keep_c [3];
    logic signed [21:0] keep_s [3];
    int cnt;

    initial begin
        repeat (2) @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset ready u%0d", unr[d]), rdy[d], 1, 0);
            chk($sformatf("reset done u%0d", unr[d]), dn[d], 0, 0);
            chk($sformatf("reset cos u%0d", unr[d]), co[d], 0, 0);
            chk($sformatf("reset sin u%0d", unr[d]), si[d], 0, 0);
        end
        aclr_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            run_op(dir_a[j], 1'b0, 1'b0);
            chk($sformatf("spec cos a=%0d", dir_a[j]), res_c[0], dir_c[j], TOL);
            chk($sformatf("spec sin a=%0d", dir_a[j]), res_s[0], dir_s[j], TOL);
        end
        foreach (edge_a[j]) run_op(edge_a[j], 1'b0, 1'b0);
        run_op(-700000, 1'b0, 1'b0);
        keep_c = res_c;
        keep_s = res_s;
        run_op(-700000, 1'b1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("stall cos same u%0d", unr[d]), res_c[d], keep_c[d], 0);
            chk($sformatf("stall sin same u%0d", unr[d]), res_s[d], keep_s[d], 0);
        end
        run_op(300000, 1'b0, 1'b1);
        @(negedge clock);
        ang = '0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        aclr_n = 1'b0;
        @(negedge clock);
        aclr_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("abort ready u%0d", unr[d]), rdy[d], 1, 0);
            chk($sformatf("abort cos u%0d", unr[d]), co[d], 0, 0);
            chk($sformatf("abort sin u%0d", unr[d]), si[d], 0, 0);
        end
        cnt = 0;
        for (int n = 0; n < 24; n++) begin
            @(negedge clock);
            if (dn != 3'b000) cnt++;
        end
        chk("done after abort", cnt, 0, 0);
        run_op(0, 1'b0, 1'b0);
        for (int j = 0; j < 1024; j++)
            run_op(int'($urandom_range(2 * PI_Q)) - PI_Q, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
